// File: rtl/updi_uart_phy.sv
// ---------------------------------------------------------------------------
// updi_uart_phy
// Single-wire, half-duplex UPDI UART stage between the loader byte stream and
// the UPDI pin.
//   TX : one byte per handshake -> start(0), 8 data LSB-first, even parity,
//        2 stop(1). Each bit is held CLK_DIV clocks.
//   RX : deserialises frames from the pin. It reports the data byte plus
//        parity and framing status in a one-cycle o_rx_valid pulse.
//   RX is blanked while the block drives the pin, so its own echo is ignored.
//
// Handshake: a TX byte transfers on a rising clk edge where i_tx_valid and
// o_tx_ready are both 1. i_tx_data is held stable while valid && !ready.
// o_tx_ready never depends on i_tx_valid.
//
// Optional feature: define UPDI_BREAK_DET_EN to build the BREAK detector.
// Without it, o_break is tied 0.
//
// Ports
//   clk, rst             clock, synchronous active-low reset
//   i_tx_data/valid      TX byte and request; o_tx_ready accepts it
//   o_rx_data/valid      received byte and one-cycle strobe
//   o_rx_perr/ferr       parity / first-stop error, qualified by o_rx_valid
//   i_line               asynchronous pin input
//   o_line, o_line_oe    pin drive value and enable
//   o_busy               FSM not idle
//   o_break              BREAK detected pulse
// ---------------------------------------------------------------------------
module updi_uart_phy #(
    parameter int CLK_DIV = 16,
    parameter int SYNC_FF = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    output logic       o_rx_perr,
    output logic       o_rx_ferr,
    input  logic       i_line,
    output logic       o_line,
    output logic       o_line_oe,
    output logic       o_busy,
    output logic       o_break
);
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    // Edge detection costs one clock after line_s falls. Stopping the start
    // count two short of the half-bit puts every sample at the bit centre, as
    // seen by the synchronised line.
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2 - 2);

    typedef enum logic [2:0] {IDLE, TX_BIT, RX_START, RX_BIT, RX_STOP} state_t;

    state_t             state;
    logic [SYNC_FF-1:0] sync_q;
    logic               line_s;
    logic               line_d;
    logic [DW-1:0]      div_cnt;
    logic [3:0]         bit_cnt;
    logic [10:0]        tx_sr;      // {stop, stop, parity, d7..d0}; start bit is driven directly
    logic [8:0]         rx_sr;      // {parity, d7..d0} once complete
    logic               rx_hold;    // all-zero frame waiting to see whether it is a BREAK
    logic               div_end;
    logic               fall;
    logic               brk_hit;
    logic               defer;

    assign line_s     = sync_q[SYNC_FF-1];
    assign div_end    = (div_cnt == DIV_LAST);
    assign fall       = line_d & ~line_s & ~o_line_oe;
    assign o_tx_ready = (state == IDLE) && line_s;
    assign o_busy     = (state != IDLE);

`ifdef UPDI_BREAK_DET_EN
    localparam int LW = $clog2(12 * CLK_DIV + 1);
    localparam logic [LW-1:0] LOW_LAST = LW'(12 * CLK_DIV - 1);
    localparam logic [LW-1:0] LOW_SAT  = LW'(12 * CLK_DIV);
    logic [LW-1:0] low_cnt;

    assign brk_hit = (state != TX_BIT) && !line_s && (low_cnt == LOW_LAST);
    // A line held low from the start bit looks like a 0x00 frame with a bad
    // stop bit at the stop sample. That result is held back until the line
    // either rises (real framing error) or the BREAK threshold is reached.
    assign defer   = !line_s && (rx_sr == '0);
`else
    assign brk_hit = 1'b0;
    assign defer   = 1'b0;
    assign o_break = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            sync_q     <= '1;
            line_d     <= 1'b1;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            tx_sr      <= '1;
            rx_sr      <= '0;
            rx_hold    <= 1'b0;
            o_line     <= 1'b1;
            o_line_oe  <= 1'b0;
            o_rx_valid <= 1'b0;
            o_rx_perr  <= 1'b0;
            o_rx_ferr  <= 1'b0;
            o_rx_data  <= 8'h00;
`ifdef UPDI_BREAK_DET_EN
            low_cnt    <= '0;
            o_break    <= 1'b0;
`endif
        end else begin
            sync_q     <= {sync_q[SYNC_FF-2:0], i_line};
            line_d     <= line_s;
            o_rx_valid <= 1'b0;
`ifdef UPDI_BREAK_DET_EN
            o_break    <= 1'b0;
            if (state == TX_BIT || line_s)
                low_cnt <= '0;
            else if (low_cnt != LOW_SAT)
                low_cnt <= low_cnt + 1'b1;   // saturates: one pulse per low period
`endif
            if (brk_hit) begin
                // Abandon any frame; edge detection re-arms only after a 1->0
                // transition, so nothing restarts until the line has gone high.
                state   <= IDLE;
                rx_hold <= 1'b0;
`ifdef UPDI_BREAK_DET_EN
                o_break <= 1'b1;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        if (fall) begin
                            state <= RX_START;
                        end else if (i_tx_valid && o_tx_ready) begin
                            tx_sr     <= {2'b11, ^i_tx_data, i_tx_data};
                            o_line    <= 1'b0;
                            o_line_oe <= 1'b1;
                            state     <= TX_BIT;
                        end
                    end
                    TX_BIT: begin
                        if (div_end) begin
                            div_cnt <= '0;
                            if (bit_cnt == 4'd11) begin
                                o_line    <= 1'b1;
                                o_line_oe <= 1'b0;
                                state     <= IDLE;
                            end else begin
                                if (bit_cnt != 4'hF) bit_cnt <= bit_cnt + 4'd1;
                                o_line <= tx_sr[0];
                                tx_sr  <= {1'b1, tx_sr[10:1]};
                            end
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                    RX_START: begin
                        if (div_cnt == DIV_HALF) begin
                            div_cnt <= '0;
                            state   <= line_s ? IDLE : RX_BIT;   // high again: glitch
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                    RX_BIT: begin
                        if (div_end) begin
                            div_cnt <= '0;
                            rx_sr   <= {line_s, rx_sr[8:1]};
                            if (bit_cnt == 4'd8)
                                state <= RX_STOP;
                            else if (bit_cnt != 4'hF)
                                bit_cnt <= bit_cnt + 4'd1;
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                    RX_STOP: begin
                        if (rx_hold) begin
                            if (line_s) begin
                                rx_hold    <= 1'b0;
                                o_rx_valid <= 1'b1;
                                o_rx_data  <= rx_sr[7:0];
                                o_rx_perr  <= (^rx_sr[7:0]) != rx_sr[8];
                                o_rx_ferr  <= 1'b1;
                                state      <= IDLE;
                            end
                        end else if (div_end) begin
                            div_cnt <= '0;
                            if (defer) begin
                                rx_hold <= 1'b1;
                            end else begin
                                // Second stop bit is left as guard time.
                                o_rx_valid <= 1'b1;
                                o_rx_data  <= rx_sr[7:0];
                                o_rx_perr  <= (^rx_sr[7:0]) != rx_sr[8];
                                o_rx_ferr  <= !line_s;
                                state      <= IDLE;
                            end
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_updi_uart_phy.sv
// ---------------------------------------------------------------------------
// tb_updi_uart_phy
// Bench for updi_uart_phy at CLK_DIV=4, SYNC_FF=2. The pin is modelled as a
// wire that the DUT drives when o_line_oe=1 and the bench drives otherwise.
// Expected RX results and TX frames are queued when stimulus is issued. The
// monitors compare them when the DUT produces output.
// ---------------------------------------------------------------------------
module tb_updi_uart_phy;
    localparam int DIV = 4;
    localparam int SFF = 2;

    // ---------------- clock / reset / pin ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       line_drv = 1'b1;
    logic       i_line;
    logic       o_tx_ready, o_rx_valid, o_rx_perr, o_rx_ferr;
    logic       o_line, o_line_oe, o_busy, o_break;
    logic [7:0] o_rx_data;

    assign i_line = o_line_oe ? o_line : line_drv;

    updi_uart_phy #(.CLK_DIV(DIV), .SYNC_FF(SFF)) dut (
        .clk(clk), .rst(rst),
        .i_tx_data(tx_data), .i_tx_valid(tx_valid), .o_tx_ready(o_tx_ready),
        .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid),
        .o_rx_perr(o_rx_perr), .o_rx_ferr(o_rx_ferr),
        .i_line(i_line), .o_line(o_line), .o_line_oe(o_line_oe),
        .o_busy(o_busy), .o_break(o_break)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          total = 0;
    int          bad = 0;
    logic [10:0] exp_q[$];      // {data, perr, ferr}
    logic [11:0] tx_q[$];       // frame bits, LSB = start bit
    int          rx_seen = 0;
    int          brk_seen = 0;
    logic        tx_abort_ok = 1'b0;
    logic        b2b_chk = 1'b0;
    int          oe_cnt = 0;
    int          gap = 0;
    logic [11:0] cap = '0;

    typedef struct {
        logic [7:0]  d;
        logic [11:0] frame;
    } tx_vec_t;

    typedef struct {
        logic [7:0] d;
        logic       par;
        logic       stop;
        logic [7:0] ed;
        logic       ep;
        logic       ef;
    } rx_vec_t;

    tx_vec_t tx_tab[7];
    rx_vec_t rx_tab[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (rst && o_rx_valid) begin
            rx_seen++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rx_unexpected: got data=%0h perr=%0b ferr=%0b, want no frame",
                         o_rx_data, o_rx_perr, o_rx_ferr);
            end else begin
                check("rx_frame", {o_rx_data, o_rx_perr, o_rx_ferr}, exp_q.pop_front());
            end
        end
        if (rst && o_break) brk_seen++;
    end

    always @(negedge clk) begin
        if (o_line_oe) begin
            if (oe_cnt == 0 && b2b_chk) begin
                check("b2b_gap", gap, 1);
                b2b_chk = 1'b0;
            end
            if (oe_cnt % DIV == DIV / 2 && oe_cnt < 12 * DIV) cap[4'(oe_cnt / DIV)] = o_line;
            oe_cnt++;
        end else begin
            if (oe_cnt != 0) begin
                if (tx_abort_ok) begin
                    tx_abort_ok = 1'b0;
                    if (tx_q.size() != 0) void'(tx_q.pop_front());
                end else begin
                    check("tx_len", oe_cnt, 12 * DIV);
                    if (tx_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL tx_unexpected: got frame %0h, want none", cap);
                    end else begin
                        check("tx_bits", cap, tx_q.pop_front());
                    end
                end
                oe_cnt = 0;
                gap = 0;
            end
            gap++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_tx(input logic [7:0] d, input logic [11:0] frame);
        int n = 0;
        tx_q.push_back(frame);
        tx_data  = d;
        tx_valid = 1'b1;
        while (o_tx_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            total++;
            bad++;
            $display("FAIL tx_accept_timeout: got no ready, want ready");
        end
        step();
        tx_valid = 1'b0;
        tx_data  = 8'h00;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge clk);
        while ((o_busy || o_line_oe) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: busy=%0b oe=%0b, want 0 0", o_busy, o_line_oe);
        end
        step();
    endtask

    task automatic drive_rx(input logic [7:0] d, input logic par, input logic stop, input int nbits);
        logic [11:0] f;
        f = {1'b1, stop, par, d, 1'b0};
        for (int b = 0; b < nbits; b++) begin
            line_drv = f[b];
            repeat (DIV) step();
        end
        line_drv = 1'b1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_line"},   o_line,     1'b1);
        check({tag, "_oe"},     o_line_oe,  1'b0);
        check({tag, "_ready"},  o_tx_ready, 1'b1);
        check({tag, "_busy"},   o_busy,     1'b0);
        check({tag, "_rxv"},    o_rx_valid, 1'b0);
        check({tag, "_perr"},   o_rx_perr,  1'b0);
        check({tag, "_ferr"},   o_rx_ferr,  1'b0);
        check({tag, "_data"},   o_rx_data,  8'h00);
        check({tag, "_break"},  o_break,    1'b0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, want end before time limit");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int          rx_before;
        int          brk_before;
        int          brk_at;
        logic        seen_busy;
        logic [7:0]  rd;
        logic        rp;

        tx_tab[0] = '{8'h55, 12'hCAA};
        tx_tab[1] = '{8'h07, 12'hE0E};
        tx_tab[2] = '{8'h80, 12'hF00};
        tx_tab[3] = '{8'hFF, 12'hDFE};
        tx_tab[4] = '{8'h00, 12'hC00};
        tx_tab[5] = '{8'hA3, 12'hD46};
        tx_tab[6] = '{8'h3C, 12'hC78};

        rx_tab[0] = '{8'hA3, 1'b0, 1'b1, 8'hA3, 1'b0, 1'b0};
        rx_tab[1] = '{8'hA3, 1'b1, 1'b1, 8'hA3, 1'b1, 1'b0};
        rx_tab[2] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
        rx_tab[3] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        rx_tab[4] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
        rx_tab[5] = '{8'h80, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0};

        // Reset
        rst = 1'b0;
        repeat (3) step();
        check_reset("reset");
        rst = 1'b1;
        repeat (3) step();

        // Single TX 0x55
        check("tx55_ready_before", o_tx_ready, 1'b1);
        send_tx(8'h55, 12'hCAA);
        wait_idle(200);
        check("tx55_ready_after", o_tx_ready, 1'b1);

        // Back-to-back 0x07 then 0x80
        send_tx(8'h07, 12'hE0E);
        repeat (2) step();
        b2b_chk = 1'b1;
        send_tx(8'h80, 12'hF00);
        wait_idle(200);
        check("b2b_checked", b2b_chk, 1'b0);

        // TX table
        for (int i = 0; i < 7; i++) begin
            send_tx(tx_tab[i].d, tx_tab[i].frame);
            wait_idle(200);
        end

        // Random TX
        for (int i = 0; i < 4; i++) begin
            rd = 8'($urandom_range(0, 255));
            send_tx(rd, {2'b11, ^rd, rd, 1'b0});
            wait_idle(200);
        end

        // Random RX
        for (int i = 0; i < 4; i++) begin
            rd = 8'($urandom_range(0, 255));
            rp = 1'($urandom_range(0, 1));
            exp_q.push_back({rd, (^rd) ^ rp, 1'b0});
            drive_rx(rd, rp, 1'b1, 12);
            repeat (4) step();
        end

        // RX table
        rx_before = rx_seen;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back({rx_tab[i].ed, rx_tab[i].ep, rx_tab[i].ef});
            drive_rx(rx_tab[i].d, rx_tab[i].par, rx_tab[i].stop, 12);
            repeat (4) step();
        end
        repeat (10) step();
        check("rx_table_count", rx_seen - rx_before, 6);
        check("rx_queue_empty", exp_q.size(), 0);

        // 1-clk glitch on idle line
        rx_before = rx_seen;
        seen_busy = 1'b0;
        line_drv = 1'b0;
        step();
        line_drv = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (o_busy) seen_busy = 1'b1;
        end
        check("glitch_busy_seen", seen_busy, 1'b1);
        check("glitch_idle", o_busy, 1'b0);
        repeat (50) step();
        check("glitch_no_frame", rx_seen - rx_before, 0);

        // Reset in the middle of an RX frame
        rx_before = rx_seen;
        drive_rx(8'h5A, 1'b0, 1'b1, 6);
        rst = 1'b0;
        step();
        check_reset("rxrst");
        rst = 1'b1;
        repeat (60) step();
        check("rxrst_no_frame", rx_seen - rx_before, 0);

        // Reset in the middle of a TX frame, then a normal TX
        send_tx(8'h96, 12'h000);
        repeat (5 * DIV + 2) step();
        tx_abort_ok = 1'b1;
        rst = 1'b0;
        step();
        check_reset("txrst");
        rst = 1'b1;
        repeat (4) step();
        send_tx(8'h01, 12'hE02);
        wait_idle(200);

        // Line held low for 60 clk
        rx_before  = rx_seen;
        brk_before = brk_seen;
        brk_at = 0;
`ifndef UPDI_BREAK_DET_EN
        exp_q.push_back({8'h00, 1'b0, 1'b1});
`endif
        line_drv = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (o_break) brk_at = k;
        end
        line_drv = 1'b1;
        repeat (30) step();
`ifdef UPDI_BREAK_DET_EN
        check("break_count", brk_seen - brk_before, 1);
        check("break_time", (brk_at >= 47 + SFF) && (brk_at <= 49 + SFF), 1'b1);
        check("break_no_frame", rx_seen - rx_before, 0);
`else
        check("lowline_no_break", brk_seen - brk_before, 0);
        check("lowline_one_frame", rx_seen - rx_before, 1);
`endif

        check("final_rx_queue", exp_q.size(), 0);
        check("final_tx_queue", tx_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
